// File: rtl/icache_refill.sv
// I-cache line-refill engine: one INCR read burst per miss, words streamed
// into the data RAM, tag/valid written only once the whole line has landed.
module icache_refill #(
    parameter int OFS_W   = 3,
    parameter int INDEX_W = 7,
    parameter int ADDR_W  = 32
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              miss_req,
    input  logic [ADDR_W-1:0]                 miss_addr,
    output logic                              busy,
    output logic                              done,
    output logic                              arvalid,
    input  logic                              arready,
    output logic [ADDR_W-1:0]                 araddr,
    output logic [7:0]                        arlen,
    input  logic                              rvalid,
    output logic                              rready,
    input  logic [31:0]                       rdata,
    input  logic                              rlast,
    output logic                              ram_wen,
    output logic [INDEX_W+OFS_W-1:0]          ram_adw,
    output logic [31:0]                       ram_din,
    output logic                              tag_wen,
    output logic [INDEX_W-1:0]                tag_idx,
    output logic [ADDR_W-INDEX_W-OFS_W-2:0]   tag_din,
    output logic                              proto_err
);

    localparam int LINE_W = ADDR_W - OFS_W - 2;
    localparam int TAG_W  = LINE_W - INDEX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [OFS_W-1:0] LAST_WORD = '1;
    localparam logic [7:0]       ARLEN_C   = 8'((1 << OFS_W) - 1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [OFS_W-1:0]   cnt;
    logic [LINE_W-1:0]  line_q;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               beat;
    logic               is_last;
    logic               unused_lsb;

    assign idx     = line_q[INDEX_W-1:0];
    assign tag     = line_q[LINE_W-1:INDEX_W];
    assign beat    = (state == S_R) & rvalid;
    assign is_last = (cnt == LAST_WORD);

    // Byte/word offset of the miss is irrelevant: the whole line is fetched.
    assign unused_lsb = ^miss_addr[OFS_W+1:0];

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (miss_req) state_nxt = S_AR;
            S_AR:   if (arready) state_nxt = S_R;
            S_R:    if (beat && is_last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            line_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && miss_req) begin
                line_q <= miss_addr[ADDR_W-1:OFS_W+2];
                cnt    <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy    = (state != S_IDLE);
    assign arvalid = (state == S_AR);
    assign rready  = (state == S_R);
    assign done    = (state == S_DONE);
    assign tag_wen = done;

    assign araddr = {line_q, {(OFS_W+2){1'b0}}};
    assign arlen  = ARLEN_C;

    // The beat counter, not rlast, decides where the line ends.
    assign ram_wen   = beat;
    assign ram_adw   = beat ? {idx, cnt} : '0;
    assign ram_din   = beat ? rdata : '0;
    assign proto_err = beat & (rlast ^ is_last);

    assign tag_idx = done ? idx : '0;
    assign tag_din = done ? {1'b1, tag} : '0;

endmodule

// File: tb/tb_icache_refill.sv
// Randomised bench for icache_refill: a bus responder drives bursts, and
// every observation is compared with a line-level model of the refill.
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        resetn;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        busy, done, arvalid, arready, rready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid, rlast;
    logic [31:0] rdata;
    logic        ram_wen;
    logic [9:0]  ram_adw;
    logic [31:0] ram_din;
    logic        tag_wen;
    logic [6:0]  tag_idx;
    logic [20:0] tag_din;
    logic        proto_err;

    icache_refill dut (
        .clk(clk), .resetn(resetn),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .busy(busy), .done(done),
        .arvalid(arvalid), .arready(arready),
        .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rlast(rlast),
        .ram_wen(ram_wen), .ram_adw(ram_adw), .ram_din(ram_din),
        .tag_wen(tag_wen), .tag_idx(tag_idx), .tag_din(tag_din),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // observations of the most recent burst
    logic [9:0]  o_adw[$];
    logic [31:0] o_din[$];
    int          o_wcyc[$];
    logic [31:0] sent[$];
    int          o_hs, o_done, o_arn, o_tagn;
    int          o_gapw, o_spur, o_arbad;
    logic [6:0]  o_tagidx;
    logic [20:0] o_tagdin;
    logic [7:0]  o_perr;
    bit          o_tmo;

    // line-level model of where a miss address lands in the cache
    function automatic logic [6:0] m_idx(input logic [31:0] a);
        return a[11:5];
    endfunction

    function automatic logic [20:0] m_tagdin(input logic [31:0] a);
        return {1'b1, a[31:12]};
    endfunction

    function automatic logic [9:0] m_adw(input logic [31:0] a, input int w);
        return {a[11:5], 3'(w)};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            miss_req = 1'b0;
            arready  = 1'b0;
            rvalid   = 1'b0;
            rlast    = 1'b0;
        end
    endtask

    // gap: 0 none, 1 every other cycle, 2 random; abort>=0 resets on that beat
    task automatic run_burst(input logic [31:0] addr, input int ar_wait,
                             input int gap, input logic [7:0] lmask,
                             input bit keep, input int abort);
        int n;
        bit hs;
        bit offer;
        logic [31:0] exp_ar;
        o_adw.delete(); o_din.delete(); o_wcyc.delete(); sent.delete();
        o_hs = -1; o_done = -1; o_arn = 0; o_tagn = 0;
        o_gapw = 0; o_spur = 0; o_arbad = 0; o_perr = '0; o_tmo = 0;
        o_tagidx = '0; o_tagdin = '0;
        n = 0; hs = 0;
        exp_ar = {addr[31:5], 5'b0};
        @(posedge clk); #1;
        miss_req = 1'b1; miss_addr = addr;
        arready = 1'b0; rvalid = 1'b0;
        rlast = 1'($urandom); rdata = $urandom;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk); #1;
            miss_req  = keep ? 1'b1 : 1'($urandom_range(0, 1));
            miss_addr = keep ? addr : $urandom;
            arready   = (c >= 1 + ar_wait);
            if (gap == 0)      offer = 1'b1;
            else if (gap == 1) offer = (c % 2 == 0);
            else               offer = ($urandom_range(0, 2) != 0);
            offer  = offer && hs && (n < 8);
            rvalid = offer;
            rdata  = $urandom;
            rlast  = offer ? ((n == 7) ^ lmask[n]) : 1'($urandom);
            if (abort >= 0 && offer && n == abort) begin
                resetn = 1'b0;
                #1;
                return;
            end
            #1;
            if (!hs && (arvalid !== 1'b1 || araddr !== exp_ar))
                o_arbad++;
            if (arvalid && arready) begin
                o_arn++;
                if (!hs) o_hs = c;
                hs = 1;
            end
            if (ram_wen) begin
                o_adw.push_back(ram_adw);
                o_din.push_back(ram_din);
                o_wcyc.push_back(c);
                if (!(rvalid && rready)) o_gapw++;
            end
            if (rvalid && rready) begin
                sent.push_back(rdata);
                if (proto_err) o_perr[n] = 1'b1;
                n++;
            end else if (proto_err) begin
                o_spur++;
            end
            if (tag_wen) begin
                o_tagn++;
                o_tagidx = tag_idx;
                o_tagdin = tag_din;
            end
            if (done) begin
                o_done = c;
                return;
            end
        end
        o_tmo = 1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        miss_req = 1'b1; miss_addr = $urandom;
        arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = $urandom;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, arvalid, rready, ram_wen, tag_wen, proto_err,
             araddr, ram_adw, ram_din, tag_idx, tag_din} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b arvalid=%b rready=%b wen=%b din=%h araddr=%h",
                     busy, arvalid, rready, ram_wen, ram_din, araddr);
        end
        tests++;
        if (arlen !== 8'd7) begin
            fails++;
            $display("FAIL reset_arlen: got %0d expected 7", arlen);
        end
        @(posedge clk); #1;
        miss_req = 1'b0; rvalid = 1'b0; arready = 1'b0; rlast = 1'b0;
        resetn = 1'b1;
        idle(2);
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        a = 32'h1FC0_0124;
        run_burst(a, 0, 0, 8'h00, 0, -1);
        tests++;
        if (o_tmo || o_done != 10) begin
            fails++;
            $display("FAIL zw_done: got cycle %0d expected 10 (timeout=%0b)", o_done, o_tmo);
        end
        tests++;
        if (o_arbad != 0 || o_hs != 1 || o_arn != 1) begin
            fails++;
            $display("FAIL zw_ar: bad=%0d hs=%0d n=%0d expected 0/1/1", o_arbad, o_hs, o_arn);
        end
        tests++;
        if (o_adw.size() != 8) begin
            fails++;
            $display("FAIL zw_nwrites: got %0d expected 8", o_adw.size());
        end
        for (int i = 0; i < 8 && i < o_adw.size(); i++) begin
            tests++;
            if (o_adw[i] !== m_adw(a, i) || o_din[i] !== sent[i] || o_wcyc[i] != 2 + i) begin
                fails++;
                $display("FAIL zw_write%0d: got adw=%h din=%h cyc=%0d expected adw=%h din=%h cyc=%0d",
                         i, o_adw[i], o_din[i], o_wcyc[i], m_adw(a, i), sent[i], 2 + i);
            end
        end
        tests++;
        if (o_tagn != 1 || o_tagidx !== 7'h09 || o_tagdin !== {1'b1, 20'h1FC00}) begin
            fails++;
            $display("FAIL zw_tag: got n=%0d idx=%h din=%h expected 1/09/%h",
                     o_tagn, o_tagidx, o_tagdin, {1'b1, 20'h1FC00});
        end
        tests++;
        if (o_perr !== 8'h00 || o_spur != 0) begin
            fails++;
            $display("FAIL zw_perr: got mask=%h spur=%0d expected 00/0", o_perr, o_spur);
        end
        idle(2);
    endtask

    task automatic test_ar_stall();
        logic [31:0] a;
        a = $urandom;
        run_burst(a, 5, 0, 8'h00, 0, -1);
        tests++;
        if (o_arbad != 0 || o_hs != 6) begin
            fails++;
            $display("FAIL stall_ar_stable: got bad=%0d hs=%0d expected 0/6", o_arbad, o_hs);
        end
        tests++;
        if (o_wcyc.size() == 0 || o_wcyc[0] <= o_hs) begin
            fails++;
            $display("FAIL stall_first_write: got %0d writes, hs=%0d", o_wcyc.size(), o_hs);
        end
        tests++;
        if (o_tmo || o_done != 15 || o_adw.size() != 8) begin
            fails++;
            $display("FAIL stall_done: got cycle %0d writes %0d expected 15/8", o_done, o_adw.size());
        end
        tests++;
        if (o_tagdin !== m_tagdin(a) || o_tagidx !== m_idx(a)) begin
            fails++;
            $display("FAIL stall_tag: got %h@%h expected %h@%h",
                     o_tagdin, o_tagidx, m_tagdin(a), m_idx(a));
        end
        idle(2);
    endtask

    task automatic test_rvalid_gaps();
        logic [31:0] a;
        a = $urandom;
        run_burst(a, 0, 1, 8'h00, 0, -1);
        tests++;
        if (o_adw.size() != 8 || o_gapw != 0) begin
            fails++;
            $display("FAIL gap_writes: got %0d writes %0d in gaps expected 8/0", o_adw.size(), o_gapw);
        end
        for (int i = 0; i < 8 && i < o_adw.size(); i++) begin
            tests++;
            if (o_adw[i] !== m_adw(a, i) || o_din[i] !== sent[i] || o_wcyc[i] != 2 + 2 * i) begin
                fails++;
                $display("FAIL gap_write%0d: got adw=%h cyc=%0d expected adw=%h cyc=%0d",
                         i, o_adw[i], o_wcyc[i], m_adw(a, i), 2 + 2 * i);
            end
        end
        tests++;
        if (o_tmo || o_done != 17) begin
            fails++;
            $display("FAIL gap_done: got cycle %0d expected 17", o_done);
        end
        idle(2);
    endtask

    task automatic test_rlast_err();
        logic [31:0] a;
        a = $urandom;
        run_burst(a, 0, 0, 8'h88, 0, -1);
        tests++;
        if (o_perr !== 8'h88 || o_spur != 0) begin
            fails++;
            $display("FAIL rlast_perr: got mask=%h spur=%0d expected 88/0", o_perr, o_spur);
        end
        tests++;
        if (o_tmo || o_done != 10 || o_adw.size() != 8 || o_tagn != 1) begin
            fails++;
            $display("FAIL rlast_done: got cycle %0d writes %0d tags %0d expected 10/8/1",
                     o_done, o_adw.size(), o_tagn);
        end
        tests++;
        if (o_tagdin !== m_tagdin(a)) begin
            fails++;
            $display("FAIL rlast_tag: got %h expected %h", o_tagdin, m_tagdin(a));
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        bit tag_seen;
        a = $urandom;
        run_burst(a, 0, 0, 8'h00, 0, 4);
        tests++;
        if ({busy, done, arvalid, rready, ram_wen, tag_wen, proto_err,
             araddr, ram_adw, ram_din, tag_idx, tag_din} !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: got busy=%b rready=%b wen=%b adw=%h din=%h",
                     busy, rready, ram_wen, ram_adw, ram_din);
        end
        tests++;
        if (o_adw.size() != 4 || o_tagn != 0) begin
            fails++;
            $display("FAIL rstmid_partial: got writes %0d tags %0d expected 4/0", o_adw.size(), o_tagn);
        end
        tag_seen = 0;
        repeat (2) begin
            @(posedge clk); #2;
            if (tag_wen) tag_seen = 1;
        end
        @(posedge clk); #1;
        resetn = 1'b1; miss_req = 1'b0; rvalid = 1'b0; arready = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            if (tag_wen || busy) tag_seen = 1;
        end
        tests++;
        if (tag_seen) begin
            fails++;
            $display("FAIL rstmid_no_tag: got tag_wen/busy after reset, expected none");
        end
        a = $urandom;
        run_burst(a, 0, 0, 8'h00, 0, -1);
        tests++;
        if (o_tmo || o_done != 10 || o_adw.size() != 8) begin
            fails++;
            $display("FAIL rstmid_refill: got cycle %0d writes %0d expected 10/8", o_done, o_adw.size());
        end
        tests++;
        if (o_adw.size() == 0 || o_adw[0] !== m_adw(a, 0) || o_tagdin !== m_tagdin(a)) begin
            fails++;
            $display("FAIL rstmid_refill_addr: got adw0=%h tag=%h expected %h/%h",
                     o_adw.size() ? o_adw[0] : 10'h0, o_tagdin, m_adw(a, 0), m_tagdin(a));
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        a = $urandom;
        b = a ^ 32'h0001_2FE0;
        run_burst(a, 0, 0, 8'h00, 1, -1);
        tests++;
        if (o_tmo || o_done != 10 || o_arn != 1 || o_tagdin !== m_tagdin(a)) begin
            fails++;
            $display("FAIL b2b_first: got done=%0d bursts=%0d tag=%h expected 10/1/%h",
                     o_done, o_arn, o_tagdin, m_tagdin(a));
        end
        run_burst(b, 0, 0, 8'h00, 1, -1);
        tests++;
        if (o_arbad != 0 || o_hs != 1 || o_arn != 1) begin
            fails++;
            $display("FAIL b2b_second_ar: got bad=%0d hs=%0d bursts=%0d expected 0/1/1",
                     o_arbad, o_hs, o_arn);
        end
        tests++;
        if (o_tmo || o_done != 10 || o_tagidx !== m_idx(b) || o_tagdin !== m_tagdin(b)) begin
            fails++;
            $display("FAIL b2b_second_tag: got done=%0d tag=%h@%h expected 10/%h@%h",
                     o_done, o_tagdin, o_tagidx, m_tagdin(b), m_idx(b));
        end
        idle(3);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [7:0]  m;
        int          w;
        int          bad;
        for (int k = 0; k < 6; k++) begin
            a = $urandom;
            m = 8'($urandom & $urandom & $urandom);
            w = $urandom_range(0, 3);
            run_burst(a, w, 2, m, 0, -1);
            bad = 0;
            for (int i = 0; i < 8 && i < o_adw.size(); i++)
                if (o_adw[i] !== m_adw(a, i) || o_din[i] !== sent[i]) bad++;
            tests++;
            if (o_tmo || o_adw.size() != 8 || bad != 0 || o_gapw != 0) begin
                fails++;
                $display("FAIL rnd%0d_line: got writes %0d bad %0d gap %0d expected 8/0/0",
                         k, o_adw.size(), bad, o_gapw);
            end
            tests++;
            if (o_wcyc.size() != 8 || o_done != o_wcyc[7] + 1 || o_hs != 1 + w) begin
                fails++;
                $display("FAIL rnd%0d_timing: got done=%0d hs=%0d expected hs=%0d",
                         k, o_done, o_hs, 1 + w);
            end
            tests++;
            if (o_perr !== m || o_spur != 0 || o_arbad != 0) begin
                fails++;
                $display("FAIL rnd%0d_perr: got %h spur %0d arbad %0d expected %h/0/0",
                         k, o_perr, o_spur, o_arbad, m);
            end
            tests++;
            if (o_tagn != 1 || o_tagidx !== m_idx(a) || o_tagdin !== m_tagdin(a)) begin
                fails++;
                $display("FAIL rnd%0d_tag: got %h@%h expected %h@%h",
                         k, o_tagdin, o_tagidx, m_tagdin(a), m_idx(a));
            end
            idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        resetn = 1'b0; miss_req = 1'b0; miss_addr = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        test_reset();
        test_zero_wait();
        test_ar_stall();
        test_rvalid_gaps();
        test_rlast_err();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
